// File: rtl/mul_arbiter_if.sv
// Bundle of requester, response and multiplier handshake signals around mul_arbiter.
// Latency: none, wiring only.
// Backpressure: carried by the ready/ack signals of each channel; master = clients plus multiplier, slave = arbiter.
interface mul_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 64,
  parameter int TAG_DEPTH = 8
);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  // requester side
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;

  // response side
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]       rsp_result;

  // multiplier issue and result side
  logic                   mul_valid;
  logic                   mul_ack;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic [WIDTH-1:0]       mul_result;
  logic                   mul_res_valid;
  logic                   mul_res_ready;

  // debug occupancy of the tag FIFO
  logic [CNT_W-1:0]       outstanding;

  // environment: client blocks plus the multiplier instance
  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_ack, mul_result, mul_res_valid,
    input  req_ready, rsp_valid, rsp_result, mul_valid, mul_a, mul_b, mul_res_ready, outstanding
  );

  // the arbiter itself
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_ack, mul_result, mul_res_valid,
    output req_ready, rsp_valid, rsp_result, mul_valid, mul_a, mul_b, mul_res_ready, outstanding
  );
endinterface

// File: rtl/mul_arbiter.sv
// Shares one pipelined multiplier among N_REQ requesters: round-robin grant, registered issue, in-order tag FIFO for result steering.
// Latency: request accepted at cycle T gives mul_valid at T+1; a result is presented to its requester in the cycle mul_res_valid is seen.
// Backpressure: loads stop while the issue register is stalled or TAG_DEPTH ops are in flight; a stalled head requester stalls the multiplier result port.
module mul_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 64,
  parameter int TAG_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  // arbitration
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] winner;
  logic             found;
  logic             can_load;
  logic             load;
  logic [N_REQ-1:0] req_ready;

  // issue register
  logic             iss_vld;
  logic [WIDTH-1:0] iss_a;
  logic [WIDTH-1:0] iss_b;

  // tag FIFO
  logic [IDX_W-1:0] tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] head;
  logic             fifo_ne;
  logic             pop;

  // result routing
  logic [N_REQ-1:0] rsp_valid;
  logic             mul_res_ready;

  // FIFO pointers wrap modulo TAG_DEPTH, which need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Round-robin search: first valid requester after the last winner, wrapping modulo N_REQ
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && bus.req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(rr_ptr) + k) % N_REQ);
      end
    end
  end

  // A load needs a free (or freeing) issue slot and a free tag; rst_n gating keeps req_ready low during reset
  assign can_load = rst_n && (!iss_vld || bus.mul_ack) && (count < CNT_W'(TAG_DEPTH));
  assign load     = found && can_load;

  // One-hot ready to the winner only; never depends on the response side
  always_comb begin
    req_ready = '0;
    if (load) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Round-robin pointer moves to the winner only on a load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= IDX_W'(N_REQ - 1);
    end else if (load) begin
      rr_ptr <= winner;
    end
  end

  // Issue register: holds operands until acked; load and ack in one cycle gives back-to-back issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_vld <= 1'b0;
      iss_a   <= '0;
      iss_b   <= '0;
    end else if (load) begin
      iss_vld <= 1'b1;
      iss_a   <= bus.req_a[int'(winner) * WIDTH +: WIDTH];
      iss_b   <= bus.req_b[int'(winner) * WIDTH +: WIDTH];
    end else if (bus.mul_ack) begin
      iss_vld <= 1'b0;
    end
  end

  // Tag storage: requester ID of each loaded op, written at the tail on load
  always_ff @(posedge clk) begin
    if (load) begin
      tag_mem[wr_ptr] <= winner;
    end
  end

  // Tag FIFO pointers and occupancy; simultaneous load and pop leave the count unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (load) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({load, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign fifo_ne = (count != '0);
  assign head    = tag_mem[rd_ptr];

  // Steer the multiplier result to the requester at the FIFO head; an orphan result is never routed
  always_comb begin
    rsp_valid = '0;
    if (bus.mul_res_valid && fifo_ne) begin
      rsp_valid[head] = 1'b1;
    end
  end

  assign mul_res_ready = fifo_ne && bus.rsp_ready[head];
  assign pop           = bus.mul_res_valid && mul_res_ready;

  assign bus.req_ready     = req_ready;
  assign bus.mul_valid     = iss_vld;
  assign bus.mul_a         = iss_a;
  assign bus.mul_b         = iss_b;
  assign bus.rsp_valid     = rsp_valid;
  assign bus.rsp_result    = bus.mul_result;
  assign bus.mul_res_ready = mul_res_ready;
  assign bus.outstanding   = count;

  // A result with no tag in flight means the multiplier broke protocol
  a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.mul_res_valid && !fifo_ne));

  // Operands must stay put while the multiplier refuses the issue
  a_issue_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (iss_vld && !bus.mul_ack) |=> (iss_vld && $stable(iss_a) && $stable(iss_b)));

  // Occupancy can never exceed the tag capacity
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CNT_W'(TAG_DEPTH));
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a queue-based pipelined multiplier model.
// Latency: model multiplier returns a product LAT-1 cycles after the issue edge.
// Backpressure: bench drives mul_ack and rsp_ready to stall issue and response paths.
module tb_mul_arbiter;
  localparam int N   = 4;
  localparam int W   = 64;
  localparam int D   = 8;
  localparam int LAT = 3;

  typedef struct {
    logic [W-1:0] p;
    int           rdy;
  } mop_t;

  typedef struct {
    int           id;
    logic [W-1:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mul_arbiter_if #(.N_REQ(N), .WIDTH(W), .TAG_DEPTH(D)) bus ();

  mul_arbiter #(.N_REQ(N), .WIDTH(W), .TAG_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mop_t mq[$];
  ev_t  grant_log[$];
  ev_t  rsp_log[$];
  int   cyc;
  int   tests;
  int   fails;

  int           bp_id  [8] = '{1, 2, 3, 0, 2, 3, 0, 2};
  logic [W-1:0] bp_val [8] = '{64'd81, 64'd33, 64'd44, 64'd22, 64'd33, 64'd44, 64'd22, 64'd33};

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic upd_mul();
    if (mq.size() > 0 && cyc >= mq[0].rdy) begin
      bus.mul_res_valid = 1'b1;
      bus.mul_result    = mq[0].p;
    end else begin
      bus.mul_res_valid = 1'b0;
      bus.mul_result    = '0;
    end
  endtask

  // One clock: sample handshakes just before the rising edge, update the multiplier model just after it
  task automatic tick();
    bit           fi;
    bit           fr;
    logic [W-1:0] pa;
    logic [W-1:0] ea;
    logic [W-1:0] eb;
    logic [W-1:0] ep;
    ev_t          e;
    @(negedge clk);
    #3;
    fi = bus.mul_valid && bus.mul_ack;
    pa = bus.mul_a * bus.mul_b;
    fr = bus.mul_res_valid && bus.mul_res_ready;
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        ea = bus.req_a[i*W +: W];
        eb = bus.req_b[i*W +: W];
        ep = ea * eb;
        grant_log.push_back('{i, ep});
      end
    end
    if (fr) begin
      e.id  = -1;
      e.val = bus.rsp_result;
      for (int i = 0; i < N; i++) begin
        if (bus.rsp_valid[i]) e.id = (e.id == -1) ? i : -2;
      end
      rsp_log.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n) begin
      if (fr) void'(mq.pop_front());
      if (fi) mq.push_back('{pa, cyc + LAT - 1});
    end else begin
      mq.delete();
    end
    upd_mul();
  endtask

  task automatic wait_rsp(input string tag, input int n, input int budget);
    int b;
    b = 0;
    while (rsp_log.size() < n && b < budget) begin
      tick();
      b++;
    end
    chk(tag, (rsp_log.size() >= n) ? 64'd1 : 64'd0, 64'd1);
  endtask

  initial begin
    int guard;
    int n0;
    tests = 0;
    fails = 0;
    cyc   = 0;

    // reset state, with requests pending to show req_ready stays low
    rst_n             = 1'b0;
    bus.req_valid     = '1;
    bus.req_a         = '0;
    bus.req_b         = '0;
    bus.rsp_ready     = '1;
    bus.mul_ack       = 1'b1;
    bus.mul_result    = '0;
    bus.mul_res_valid = 1'b0;
    #2;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_mul_valid", bus.mul_valid, 0);
    chk("rst_mul_a", bus.mul_a, 0);
    chk("rst_mul_b", bus.mul_b, 0);
    chk("rst_mul_res_ready", bus.mul_res_ready, 0);
    chk("rst_outstanding", bus.outstanding, 0);
    tick();
    tick();
    rst_n         = 1'b1;
    bus.req_valid = '0;

    // single request from requester 2: 3*5
    set_op(2, 3, 5);
    bus.req_valid = 4'b0100;
    #1;
    chk("single_req_ready", bus.req_ready, 4'b0100);
    chk("single_mul_valid_pre", bus.mul_valid, 0);
    grant_log.delete();
    rsp_log.delete();
    tick();
    bus.req_valid = '0;
    #1;
    chk("single_mul_valid", bus.mul_valid, 1);
    chk("single_mul_a", bus.mul_a, 3);
    chk("single_mul_b", bus.mul_b, 5);
    chk("single_outstanding", bus.outstanding, 1);
    wait_rsp("single_rsp_timeout", 1, 20);
    if (rsp_log.size() >= 1) begin
      chk("single_rsp_id", rsp_log[0].id, 2);
      chk("single_rsp_val", rsp_log[0].val, 15);
    end
    chk("single_outstanding_done", bus.outstanding, 0);

    // round robin from a fresh pointer: all four requesters, a=i+1, b=10
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    rsp_log.delete();
    for (int i = 0; i < N; i++) set_op(i, i + 1, 10);
    bus.req_valid = 4'b1111;
    guard = 0;
    while (grant_log.size() < 8 && guard < 30) begin
      tick();
      guard++;
    end
    bus.req_valid = '0;
    chk("rr_grant_count", grant_log.size(), 8);
    for (int k = 0; k < 8 && k < grant_log.size(); k++) chk("rr_grant_order", grant_log[k].id, k % 4);
    wait_rsp("rr_rsp_timeout", 8, 40);
    for (int k = 0; k < 8 && k < rsp_log.size(); k++) begin
      chk("rr_rsp_id", rsp_log[k].id, k % 4);
      chk("rr_rsp_val", rsp_log[k].val, (k % 4 + 1) * 10);
    end

    // multiplier stall: requester 0 loads, mul_ack held low for 5 cycles, requester 1 waits
    grant_log.delete();
    rsp_log.delete();
    bus.mul_ack = 1'b0;
    set_op(0, 100, 7);
    set_op(1, 200, 3);
    bus.req_valid = 4'b0011;
    #1;
    chk("stall_first_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_req_ready", bus.req_ready, 0);
      chk("stall_mul_valid", bus.mul_valid, 1);
      chk("stall_mul_a", bus.mul_a, 100);
      chk("stall_mul_b", bus.mul_b, 7);
      tick();
    end
    bus.mul_ack = 1'b1;
    #1;
    chk("stall_ack_ready", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = '0;
    #1;
    chk("stall_b2b_valid", bus.mul_valid, 1);
    chk("stall_b2b_a", bus.mul_a, 200);
    chk("stall_b2b_b", bus.mul_b, 3);
    wait_rsp("stall_rsp_timeout", 2, 20);
    if (rsp_log.size() >= 2) begin
      chk("stall_rsp0_id", rsp_log[0].id, 0);
      chk("stall_rsp0_val", rsp_log[0].val, 700);
      chk("stall_rsp1_id", rsp_log[1].id, 1);
      chk("stall_rsp1_val", rsp_log[1].val, 600);
    end

    // response back-pressure: requester 1 result held at head until the tag FIFO fills
    grant_log.delete();
    rsp_log.delete();
    bus.rsp_ready = 4'b1101;
    set_op(1, 9, 9);
    bus.req_valid = 4'b0010;
    tick();
    set_op(0, 2, 11);
    set_op(2, 3, 11);
    set_op(3, 4, 11);
    bus.req_valid = 4'b1101;
    guard = 0;
    while (bus.outstanding != D && guard < 30) begin
      tick();
      guard++;
    end
    for (int k = 0; k < 4; k++) tick();
    #1;
    chk("bp_outstanding_full", bus.outstanding, D);
    chk("bp_req_ready", bus.req_ready, 0);
    chk("bp_mul_res_ready", bus.mul_res_ready, 0);
    chk("bp_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("bp_rsp_result", bus.rsp_result, 81);
    chk("bp_grant_count", grant_log.size(), 8);
    bus.rsp_ready = 4'b1111;
    bus.req_valid = '0;
    wait_rsp("bp_rsp_timeout", 8, 60);
    for (int k = 0; k < 8 && k < rsp_log.size(); k++) begin
      chk("bp_rsp_id", rsp_log[k].id, bp_id[k]);
      chk("bp_rsp_val", rsp_log[k].val, bp_val[k]);
    end
    chk("bp_outstanding_done", bus.outstanding, 0);

    // wrap: 3*TAG_DEPTH random ops with random mul_ack and rsp_ready, first op 2^63*2
    grant_log.delete();
    rsp_log.delete();
    set_op(0, 64'h8000_0000_0000_0000, 2);
    for (int i = 1; i < N; i++) set_op(i, rnd64(), rnd64());
    bus.req_valid = 4'b0001;
    tick();
    set_op(0, rnd64(), rnd64());
    bus.req_valid = 4'b1111;
    guard = 0;
    while (grant_log.size() < 3 * D && guard < 400) begin
      n0 = grant_log.size();
      tick();
      guard++;
      if (grant_log.size() > n0) set_op(grant_log[n0].id, rnd64(), rnd64());
      bus.rsp_ready = 4'($urandom_range(0, 15));
      bus.mul_ack   = ($urandom_range(0, 3) != 0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    bus.mul_ack   = 1'b1;
    chk("wrap_grant_count", grant_log.size(), 3 * D);
    wait_rsp("wrap_rsp_timeout", 3 * D, 300);
    if (rsp_log.size() >= 1) begin
      chk("wrap_overflow_id", rsp_log[0].id, 0);
      chk("wrap_overflow_val", rsp_log[0].val, 0);
    end
    for (int k = 0; k < 3 * D && k < rsp_log.size() && k < grant_log.size(); k++) begin
      chk("wrap_rsp_id", rsp_log[k].id, grant_log[k].id);
      chk("wrap_rsp_val", rsp_log[k].val, grant_log[k].val);
    end
    chk("wrap_outstanding_done", bus.outstanding, 0);

    // reset mid-flight with 3 ops outstanding, then a clean 7*6 from requester 0
    grant_log.delete();
    rsp_log.delete();
    bus.rsp_ready = '0;
    for (int i = 0; i < N; i++) set_op(i, i + 2, 3);
    bus.req_valid = 4'b1111;
    tick();
    tick();
    tick();
    #1;
    chk("midrst_outstanding_pre", bus.outstanding, 3);
    rst_n = 1'b0;
    mq.delete();
    upd_mul();
    #1;
    chk("midrst_req_ready", bus.req_ready, 0);
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_mul_valid", bus.mul_valid, 0);
    chk("midrst_mul_a", bus.mul_a, 0);
    chk("midrst_mul_b", bus.mul_b, 0);
    chk("midrst_mul_res_ready", bus.mul_res_ready, 0);
    chk("midrst_outstanding", bus.outstanding, 0);
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    rsp_log.delete();
    bus.rsp_ready = '1;
    set_op(0, 7, 6);
    bus.req_valid = 4'b0001;
    #1;
    chk("post_rst_req_ready", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = '0;
    wait_rsp("post_rst_rsp_timeout", 1, 20);
    if (rsp_log.size() >= 1) begin
      chk("post_rst_rsp_id", rsp_log[0].id, 0);
      chk("post_rst_rsp_val", rsp_log[0].val, 42);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one pipelined 64-bit multiplier between N_REQ requesters.
- Round-robin grant on the request side. Issued operands go through a registered issue stage.
- Each in-flight operation carries a requester ID in an in-order tag FIFO. Results are steered back to the originating requester.
- Sits between client blocks (address generators, hash units) and the mul instance. The multiplier itself is unmodified.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 64, operand/result width; must match the multiplier.
- TAG_DEPTH, 8, maximum operations loaded but not yet retired; must be ≥ multiplier latency + 2 for full throughput.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept.
- req_a  in  N_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing.
- rsp_valid  out  N_REQ  result valid for requester i.
- rsp_ready  in  N_REQ  requester i accepts result.
- rsp_result  out  WIDTH  shared result bus; meaningful for the requester whose rsp_valid is high.
- mul_valid  out  1  issue valid to multiplier.
- mul_ack  in  1  multiplier accepted issue.
- mul_a  out  WIDTH  operand A to multiplier.
- mul_b  out  WIDTH  operand B to multiplier.
- mul_result  in  WIDTH  multiplier result.
- mul_res_valid  in  1  multiplier result valid.
- mul_res_ready  out  1  arbiter accepts result.
- outstanding  out  $clog2(TAG_DEPTH+1)  tag FIFO occupancy, for debug.

Behaviour:
- Reset (async, rst_n low): all of the following clear immediately.
  - req_ready=0, rsp_valid=0, mul_valid=0, mul_a=mul_b=0, mul_res_ready=0, outstanding=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - Tag FIFO empty; issue register empty.
- Reset mid-operation: in-flight operations are discarded. The multiplier shares rst_n, so no stale result returns.
- Handshakes: a transfer occurs when valid && ready in the same cycle.
  - Requester side: req_valid[i]/req_ready[i].
  - Multiplier issue side: mul_valid/mul_ack.
  - Multiplier result side: mul_res_valid/mul_res_ready.
  - Response side: rsp_valid[i]/rsp_ready[i].
- Arbitration (combinational):
  - Winner = first i with req_valid[i]=1, searching from pointer+1 upward, wrapping modulo N_REQ.
  - can_load = (issue register empty OR mul_ack=1) AND outstanding < TAG_DEPTH.
  - req_ready[winner] = can_load; all other req_ready bits = 0.
  - req_ready never depends on rsp_ready.
- Load (clock edge with req_valid[w] && req_ready[w]):
  - Issue register captures req_a/req_b of w; mul_valid=1 from the next cycle.
  - w is pushed to the tag FIFO.
  - Pointer is set to w. The pointer does not change on cycles with no load.
- Issue register:
  - mul_a/mul_b/mul_valid are driven directly from flops and held stable while mul_valid=1 and mul_ack=0.
  - Cleared on mul_ack unless reloaded in the same cycle. Load plus ack in one cycle gives back-to-back issue.
- Latency: request accepted at cycle T → mul_valid at T+1. Response appears the same cycle mul_res_valid is seen; no extra register.
- Result routing, with head = tag FIFO head:
  - rsp_valid[head] = mul_res_valid AND FIFO not empty; other rsp_valid bits = 0.
  - rsp_result = mul_result.
  - mul_res_ready = rsp_ready[head] AND FIFO not empty.
  - The FIFO pops when mul_res_valid && mul_res_ready.
- Ordering: results return in issue order, so FIFO order equals multiplier order.
- A stalled requester (rsp_ready=0) back-pressures the multiplier and every later result. This is accepted; no reorder buffer.
- outstanding: +1 on load, -1 on pop, unchanged when both occur in one cycle. At TAG_DEPTH, no load in that cycle even if a pop occurs.
- Error guard: mul_res_valid with the FIFO empty is a protocol error. The result is not routed, mul_res_ready=0, and a simulation assertion fires.
- Width: operands pass through unmodified. The result is the low WIDTH bits of the product, exactly as the multiplier produces it.
- Wrap-around: FIFO read/write pointers wrap modulo TAG_DEPTH; the RR pointer wraps modulo N_REQ.

Test Plan:
- Single request: req 2 sends a=3, b=5, rsp_ready all 1 → mul_valid one cycle after accept; rsp_valid[2]=1 with rsp_result=15; outstanding returns to 0.
- Round robin: all 4 requesters hold req_valid continuously, operands a=i+1, b=10 → grants 0,1,2,3,0,...; results 10,20,30,40 in that order, each on the correct rsp_valid bit.
- Multiplier stall: hold mul_ack=0 for 5 cycles with one operation loaded → mul_a/mul_b stable, no further req_ready; on ack, the next winner loads in that same cycle.
- Response back-pressure: rsp_ready[1]=0 while its result is at the head → mul_res_ready=0; loads continue until outstanding=TAG_DEPTH (8), then req_ready=0; releasing rsp_ready[1] drains all results in order.
- Wrap: 3*TAG_DEPTH random operations across requesters → every product matches the reference model (a*b mod 2^64), e.g. a=2^63, b=2 → 0; the tag FIFO wraps cleanly.
- Reset mid-flight: assert rst_n low with 3 operations outstanding → all outputs 0 immediately; after release, a request from req 0 with a=7, b=6 returns 42.
